// File: rtl/lexer_pkg.sv
// rtl/lexer_pkg.sv - shared token codes, FSM encodings and length helpers for the scanner
package lexer_pkg;

  localparam int MAX_LEN_DEFAULT = 255;

  typedef enum logic [1:0] {
    TOK_NONE   = 2'd0,
    TOK_IDENT  = 2'd1,
    TOK_NUMBER = 2'd2
  } tok_type_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IDENT  = 2'd1,
    ST_NUMBER = 2'd2
  } state_t;

  typedef struct packed {
    tok_type_t   typ;
    logic [15:0] pos;
    logic [7:0]  len;
    logic        ovf;
  } token_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] lim);
    return (v >= lim) ? lim : v + 8'd1;
  endfunction

endpackage

// File: rtl/token_scanner_if.sv
// rtl/token_scanner_if.sv - character input and token output handshakes of the scanner
interface token_scanner_if;

  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_char;
  logic        in_last;
  logic        tok_valid;
  logic        tok_ready;
  logic [1:0]  tok_type;
  logic [15:0] tok_pos;
  logic [7:0]  tok_len;
  logic        tok_ovf;

  modport master (
    output in_valid, in_char, in_last, tok_ready,
    input  in_ready, tok_valid, tok_type, tok_pos, tok_len, tok_ovf
  );

  modport slave (
    input  in_valid, in_char, in_last, tok_ready,
    output in_ready, tok_valid, tok_type, tok_pos, tok_len, tok_ovf
  );

endinterface

// File: rtl/char_class.sv
// rtl/char_class.sv - combinational ASCII classifier: letter, digit, otherwise separator
module char_class (
  input  logic [7:0] ch,
  output logic       is_letter,
  output logic       is_digit
);

  assign is_letter = ((ch >= 8'h41) && (ch <= 8'h5A)) ||
                     ((ch >= 8'h61) && (ch <= 8'h7A));
  assign is_digit  = (ch >= 8'h30) && (ch <= 8'h39);

endmodule

// File: rtl/token_scanner.sv
// rtl/token_scanner.sv - splits a character stream into IDENT/NUMBER token records
module token_scanner
  import lexer_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEFAULT
) (
  input logic           clk,
  input logic           rst_n,
  token_scanner_if.slave bus
);

  localparam logic [7:0] LEN_LIM = 8'(MAX_LEN);

  state_t      state, state_d;
  logic [15:0] idx;
  logic [15:0] cur_pos, pos_d;
  logic [7:0]  cur_len, len_d;
  logic        cur_ovf, ovf_d;

  token_t      out_q, emit_tok, held_tok, hold_tok_d, closing;
  logic        out_valid, held_valid;
  logic        emit, hold_set;
  logic        is_letter, is_digit;
  logic        out_free, accept;

  char_class u_class (
    .ch        (bus.in_char),
    .is_letter (is_letter),
    .is_digit  (is_digit)
  );

  assign out_free     = !out_valid || bus.tok_ready;
  // A held IDENT (letter that both closed a NUMBER and ended the stream) blocks input
  assign bus.in_ready = out_free && !held_valid;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d      = state;
    pos_d        = cur_pos;
    len_d        = cur_len;
    ovf_d        = cur_ovf;
    emit         = 1'b0;
    emit_tok.typ = TOK_NONE;
    emit_tok.pos = cur_pos;
    emit_tok.len = cur_len;
    emit_tok.ovf = cur_ovf;
    hold_set     = 1'b0;
    hold_tok_d   = '0;
    closing      = '0;

    if (accept) begin
      case (state)
        ST_IDLE: begin
          if (is_letter || is_digit) begin
            state_d = is_letter ? ST_IDENT : ST_NUMBER;
            pos_d   = idx;
            len_d   = 8'd1;
            ovf_d   = 1'b0;
          end
        end
        ST_IDENT: begin
          if (is_letter || is_digit) begin
            len_d = sat_inc(cur_len, LEN_LIM);
            ovf_d = cur_ovf || (cur_len >= LEN_LIM);
          end else begin
            emit         = 1'b1;
            emit_tok.typ = TOK_IDENT;
            state_d      = ST_IDLE;
          end
        end
        ST_NUMBER: begin
          if (is_digit) begin
            len_d = sat_inc(cur_len, LEN_LIM);
            ovf_d = cur_ovf || (cur_len >= LEN_LIM);
          end else begin
            emit         = 1'b1;
            emit_tok.typ = TOK_NUMBER;
            if (is_letter) begin
              state_d = ST_IDENT;
              pos_d   = idx;
              len_d   = 8'd1;
              ovf_d   = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // End of stream closes whatever is still open after normal processing
      if (bus.in_last && (state_d != ST_IDLE)) begin
        closing.typ = (state_d == ST_NUMBER) ? TOK_NUMBER : TOK_IDENT;
        closing.pos = pos_d;
        closing.len = len_d;
        closing.ovf = ovf_d;
        if (emit) begin
          hold_set   = 1'b1;
          hold_tok_d = closing;
        end else begin
          emit     = 1'b1;
          emit_tok = closing;
        end
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      idx     <= 16'd0;
      cur_pos <= 16'd0;
      cur_len <= 8'd0;
      cur_ovf <= 1'b0;
    end else if (accept) begin
      state   <= state_d;
      cur_pos <= pos_d;
      cur_len <= len_d;
      cur_ovf <= ovf_d;
      idx     <= bus.in_last ? 16'd0 : idx + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_q      <= '0;
      held_valid <= 1'b0;
      held_tok   <= '0;
    end else begin
      if (out_valid && bus.tok_ready) begin
        out_valid <= 1'b0;
      end
      if (held_valid && out_free) begin
        out_valid  <= 1'b1;
        out_q      <= held_tok;
        held_valid <= 1'b0;
      end else if (emit) begin
        out_valid <= 1'b1;
        out_q     <= emit_tok;
      end
      if (hold_set) begin
        held_valid <= 1'b1;
        held_tok   <= hold_tok_d;
      end
    end
  end

  assign bus.tok_valid = out_valid;
  assign bus.tok_type  = out_q.typ;
  assign bus.tok_pos   = out_q.pos;
  assign bus.tok_len   = out_q.len;
  assign bus.tok_ovf   = out_q.ovf;

endmodule

// File: tb/tb_token_scanner.sv
// tb/tb_token_scanner.sv - scoreboard bench for token_scanner with a string-level reference model
module tb_token_scanner;

  localparam int MAX_LEN = 255;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  token_scanner_if bus ();

  token_scanner #(.MAX_LEN(MAX_LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int typ;
    int pos;
    int len;
    bit ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   model_idx = 0;
  bit   rand_ready = 1'b0;
  bit   ready_force = 1'b1;
  bit   gaps = 1'b0;

  task automatic check(input string name, input bit ok, input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic bit is_let(input logic [7:0] c);
    return (c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A);
  endfunction

  function automatic bit is_dig(input logic [7:0] c);
    return c >= 8'h30 && c <= 8'h39;
  endfunction

  // Tokens are maximal runs; a run still open at the end of a non-final stream is not emitted
  function automatic void model(input string s, input bit last);
    int   n = s.len();
    int   i = 0;
    int   j;
    int   typ;
    exp_t e;
    while (i < n) begin
      j = i + 1;
      if (is_let(s[i])) begin
        while (j < n && (is_let(s[j]) || is_dig(s[j]))) j++;
        typ = 1;
      end else if (is_dig(s[i])) begin
        while (j < n && is_dig(s[j])) j++;
        typ = 2;
      end else begin
        typ = 0;
      end
      if (typ != 0 && (j < n || last)) begin
        e.typ = typ;
        e.pos = (model_idx + i) % 65536;
        e.len = (j - i > MAX_LEN) ? MAX_LEN : j - i;
        e.ovf = (j - i > MAX_LEN);
        exp_q.push_back(e);
      end
      i = j;
    end
    model_idx = last ? 0 : (model_idx + n) % 65536;
  endfunction

  initial begin
    bus.tok_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.tok_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
    end
  end

  initial begin : monitor
    exp_t        e;
    bit          hold_seen = 1'b0;
    logic [1:0]  h_type = '0;
    logic [15:0] h_pos = '0;
    logic [7:0]  h_len = '0;
    logic        h_ovf = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_seen = 1'b0;
      end else begin
        if (hold_seen) begin
          check("tok_stable", bus.tok_valid && bus.tok_type == h_type && bus.tok_pos == h_pos &&
                bus.tok_len == h_len && bus.tok_ovf == h_ovf, int'(bus.tok_pos), int'(h_pos));
        end
        if (bus.tok_valid && bus.tok_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_token", 1'b0, int'(bus.tok_pos), -1);
          end else begin
            e = exp_q.pop_front();
            checks++;
            if (!(bus.tok_type == e.typ && bus.tok_pos == e.pos && bus.tok_len == e.len &&
                  bus.tok_ovf == e.ovf)) begin
              failures++;
              $display("FAIL token actual type=%0d pos=%0d len=%0d ovf=%0d required type=%0d pos=%0d len=%0d ovf=%0d",
                       bus.tok_type, bus.tok_pos, bus.tok_len, bus.tok_ovf, e.typ, e.pos, e.len, e.ovf);
            end
          end
        end
        hold_seen = bus.tok_valid && !bus.tok_ready;
        h_type = bus.tok_type;
        h_pos  = bus.tok_pos;
        h_len  = bus.tok_len;
        h_ovf  = bus.tok_ovf;
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_tok_valid", bus.tok_valid == 1'b0, int'(bus.tok_valid), 0);
    check("rst_tok_type", bus.tok_type == 2'd0, int'(bus.tok_type), 0);
    check("rst_tok_pos", bus.tok_pos == 16'd0, int'(bus.tok_pos), 0);
    check("rst_tok_len", bus.tok_len == 8'd0, int'(bus.tok_len), 0);
    check("rst_tok_ovf", bus.tok_ovf == 1'b0, int'(bus.tok_ovf), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    model_idx = 0;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", bus.in_ready == 1'b1, int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_char(input logic [7:0] c, input bit last);
    int t = 0;
    if (gaps) begin
      while ($urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    bus.in_valid = 1'b1;
    bus.in_char  = c;
    bus.in_last  = last;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      t++;
      if (t > 1000) begin
        check("in_ready_timeout", 1'b0, t, 1000);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_stream(input string s, input bit last);
    model(s, last);
    for (int i = 0; i < s.len(); i++) begin
      send_char(s[i], last && (i == s.len() - 1));
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || bus.tok_valid) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("drain", t < 3000, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin : stimulus
    string s;
    int    len;
    int    r;
    bit    last;
    logic [7:0] c;

    bus.in_valid = 1'b0;
    bus.in_char  = 8'h00;
    bus.in_last  = 1'b0;
    do_reset();

    send_stream("abc012*", 1'b0);
    check("latency_after_sep", bus.tok_valid == 1'b1 && bus.tok_type == 2'd1, int'(bus.tok_valid), 1);
    wait_drain();

    do_reset();
    send_stream("12ab ", 1'b0);
    wait_drain();

    do_reset();
    ready_force = 1'b0;
    @(posedge clk);
    #2;
    fork
      send_stream("a1 b2 ", 1'b0);
      begin
        int t = 0;
        while (!bus.tok_valid && t < 200) begin
          @(negedge clk);
          t++;
        end
        check("first_token_seen", bus.tok_valid == 1'b1, int'(bus.tok_valid), 1);
        repeat (3) @(negedge clk);
        check("in_ready_backpressure", bus.in_ready == 1'b0, int'(bus.in_ready), 0);
        check("stalled_tok_len", bus.tok_pos == 16'd0 && bus.tok_len == 8'd2, int'(bus.tok_len), 2);
        ready_force = 1'b1;
      end
    join
    wait_drain();

    do_reset();
    s = "";
    for (int k = 0; k < 300; k++) s = {s, "x"};
    s = {s, ";"};
    send_stream(s, 1'b0);
    wait_drain();
    for (int k = MAX_LEN - 1; k <= MAX_LEN + 1; k++) begin
      s = "";
      for (int m = 0; m < k; m++) s = {s, "q"};
      send_stream(s, 1'b1);
    end
    wait_drain();

    do_reset();
    send_stream("99", 1'b1);
    send_stream("7a;", 1'b0);
    wait_drain();

    do_reset();
    send_stream("5a", 1'b1);
    check("held_ident_blocks_input", bus.in_ready == 1'b0, int'(bus.in_ready), 0);
    send_stream("c;", 1'b0);
    wait_drain();

    do_reset();
    send_stream("ab", 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    do_reset();
    send_stream("z;", 1'b0);
    wait_drain();

    rand_ready = 1'b1;
    gaps = 1'b1;
    for (int n = 0; n < 40; n++) begin
      s = "";
      len = $urandom_range(1, 24);
      for (int k = 0; k < len; k++) begin
        r = $urandom_range(0, 9);
        if (r < 4) c = ($urandom_range(0, 1) != 0) ? 8'(8'h41 + $urandom_range(0, 25)) : 8'(8'h61 + $urandom_range(0, 25));
        else if (r < 7) c = 8'(8'h30 + $urandom_range(0, 9));
        else c = 8'($urandom_range(1, 255));
        s = {s, " "};
        s[s.len() - 1] = c;
      end
      last = ($urandom_range(0, 3) != 0);
      if (!last) s = {s, ";"};
      send_stream(s, last);
    end
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
